// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack sequencer: FSM state encoding,
// default geometry and SP count-direction values.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_DRV  = 3'd1,
    P_STEP = 3'd2,
    Q_STEP = 3'd3,
    Q_READ = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam int NIBBLES_DEF = 3;
  localparam int DEPTH_DEF   = 256;

  localparam logic SP_DIR_PUSH = 1'b1;
  localparam logic SP_DIR_POP  = 1'b0;

endpackage

// File: rtl/stack_seq_if.sv
// CPU request/response handshake plus SP-block control strobes of the stack sequencer.
interface stack_seq_if #(
  parameter int NIBBLES = stack_seq_pkg::NIBBLES_DEF
);
  logic                 push_req;
  logic                 pop_req;
  logic [4*NIBBLES-1:0] push_data;
  logic [4*NIBBLES-1:0] pop_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 nsk_en;
  logic                 sp_d_nu;
  logic                 spc;

  modport master (
    output push_req, pop_req, push_data,
    input  pop_data, busy, done, err, nsk_en, sp_d_nu, spc
  );

  modport slave (
    input  push_req, pop_req, push_data,
    output pop_data, busy, done, err, nsk_en, sp_d_nu, spc
  );
endinterface

// File: rtl/stack_seq.sv
// Stack sequencer: turns one-shot multi-nibble PUSH/POP requests into SP-block strobes
// and STOREBUS nibble transfers. Define STACK_GUARD_EN for overflow/underflow rejection.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  stack_seq_if.slave io_bus,
  inout  wire  [3:0] io_storebus
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e        r_state;
  logic [W-1:0]  r_data;
  logic [W-1:0]  r_shadow;
  logic [W-1:0]  r_pop_data;
  logic [W-1:0]  w_shadow_nxt;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_inc;
  logic [3:0]    r_sb_out;
  logic          r_sb_oe;
  logic          r_nsk_en;
  logic          r_sp_dir;
  logic          r_spc;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_push_ok;
  logic          w_pop_ok;

`ifdef STACK_GUARD_EN
  localparam int LW = $clog2(DEPTH) + 1;
  logic [LW-1:0] r_level;
  assign w_push_ok = (r_level <= LW'(DEPTH - NIBBLES));
  assign w_pop_ok  = (r_level >= LW'(NIBBLES));
`else
  assign w_push_ok = 1'b1;
  assign w_pop_ok  = 1'b1;
`endif

  assign w_k_inc = r_k + KW'(1);

  // Nibble demux: the bus nibble read this cycle merged into the shadow word.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[{r_k, 2'b00} +: 4] = io_storebus;
  end

  // Sequencer FSM with registered strobes, bus drive and status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_shadow   <= '0;
      r_pop_data <= '0;
      r_k        <= '0;
      r_sb_out   <= 4'h0;
      r_sb_oe    <= 1'b0;
      r_nsk_en   <= 1'b1;
      r_sp_dir   <= SP_DIR_POP;
      r_spc      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef STACK_GUARD_EN
      r_level    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_spc  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.push_req) begin
            if (w_push_ok) begin
              r_data   <= io_bus.push_data;
              r_k      <= '0;
              r_sb_out <= io_bus.push_data[3:0];
              r_sb_oe  <= 1'b1;
              r_nsk_en <= 1'b0;
              r_sp_dir <= SP_DIR_PUSH;
              r_busy   <= 1'b1;
              r_state  <= P_DRV;
            end else begin
              r_err <= 1'b1;
            end
          end else if (io_bus.pop_req) begin
            if (w_pop_ok) begin
              r_k      <= KW'(NIBBLES - 1);
              r_nsk_en <= 1'b0;
              r_spc    <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= Q_STEP;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        P_DRV: begin
          r_spc   <= 1'b1;
          r_state <= P_STEP;
        end
        P_STEP: begin
          if (r_k < KW'(NIBBLES - 1)) begin
            r_k      <= w_k_inc;
            r_sb_out <= r_data[{w_k_inc, 2'b00} +: 4];
            r_state  <= P_DRV;
          end else begin
            r_sb_oe  <= 1'b0;
            r_nsk_en <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= FIN;
          end
        end
        Q_STEP: begin
          r_state <= Q_READ;
        end
        Q_READ: begin
          r_shadow <= w_shadow_nxt;
          if (r_k != '0) begin
            r_k     <= r_k - KW'(1);
            r_spc   <= 1'b1;
            r_state <= Q_STEP;
          end else begin
            r_pop_data <= w_shadow_nxt;
            r_nsk_en   <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= FIN;
          end
        end
        FIN: begin
`ifdef STACK_GUARD_EN
          if (r_sp_dir == SP_DIR_PUSH) begin
            r_level <= r_level + LW'(NIBBLES);
          end else begin
            r_level <= r_level - LW'(NIBBLES);
          end
`endif
          // Direction returns to pop only once nSK_EN is already high.
          r_sp_dir <= SP_DIR_POP;
          r_k      <= '0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_sb_oe  <= 1'b0;
          r_nsk_en <= 1'b1;
          r_sp_dir <= SP_DIR_POP;
          r_busy   <= 1'b0;
          r_k      <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign io_storebus     = r_sb_oe ? r_sb_out : 4'bzzzz;
  assign io_bus.pop_data = r_pop_data;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign io_bus.nsk_en   = r_nsk_en;
  assign io_bus.sp_d_nu  = r_sp_dir;
  assign io_bus.spc      = r_spc;

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- CPU-side sequencer that drives the stack-pointer/stack-RAM block through its control lines: nSK_EN, SP_D_nU, SPC and the 4-bit STOREBUS.
- Converts one-shot PUSH/POP requests of a multi-nibble word into the per-nibble bus and strobe sequence.
- Used for CALL/RET return-address transfers.
- Tracks stack fill level for overflow/underflow detection.

Parameters:
- NIBBLES, 3, nibbles per stacked word (word width = 4*NIBBLES).
- DEPTH, 256, stack capacity in nibbles.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- PUSH_REQ  input  1  start push; sampled only in IDLE.
- POP_REQ  input  1  start pop; sampled only in IDLE.
- PUSH_DATA  input  4*NIBBLES  word to push; captured with PUSH_REQ.
- POP_DATA  output  4*NIBBLES  last popped word; held until the next pop completes.
- BUSY  output  1  high while a transfer is in progress.
- DONE  output  1  one-cycle pulse when a transfer completes.
- ERR  output  1  one-cycle pulse when a request is rejected.
- nSK_EN  output  1  stack enable to the SP block, active low.
- SP_D_nU  output  1  1 = push (write, SP counts down), 0 = pop (read, SP counts up).
- SPC  output  1  SP count strobe; one-cycle high pulse per nibble.
- STOREBUS  inout  4  nibble bus; driven only during push states, otherwise high-Z.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, nSK_EN=1, SP_D_nU=0, SPC=0, STOREBUS=Z, BUSY=0, DONE=0, ERR=0, POP_DATA=0, level=0, nibble index=0.
- States: IDLE, P_DRV, P_STEP, Q_STEP, Q_READ, FIN.
- IDLE:
  - Outputs: nSK_EN=1, SPC=0, STOREBUS=Z.
  - PUSH_REQ=1: latch PUSH_DATA, index k=0, go to P_DRV.
  - Otherwise POP_REQ=1: k=NIBBLES-1, go to Q_STEP.
  - Both high: push wins; the pop is dropped, not queued.
  - Requests arriving while BUSY are ignored.
- P_DRV: nSK_EN=0, SP_D_nU=1, STOREBUS=latched nibble k (k=0 is the LS nibble), SPC=0. This is the write cycle. Next state P_STEP.
- P_STEP:
  - Same drive as P_DRV, plus SPC=1 (post-decrement).
  - k<NIBBLES-1: k++ and go to P_DRV. Otherwise go to FIN.
- Q_STEP: nSK_EN=0, SP_D_nU=0, SPC=1 (pre-increment), STOREBUS=Z. Next state Q_READ.
- Q_READ:
  - SPC=0. At the end of the cycle, STOREBUS is sampled into nibble k of a shadow register.
  - k>0: k-- and go to Q_STEP.
  - Otherwise go to FIN.
  - Nibbles are popped MS first, the reverse of push order.
- FIN:
  - nSK_EN=1, DONE=1 for one cycle.
  - Pop only: shadow register copied to POP_DATA in this same cycle.
  - Push: level += NIBBLES. Pop: level -= NIBBLES.
  - Next state IDLE.
- BUSY=1 in every state except IDLE.
- Latency (PUSH_REQ sampled at edge t): first P_DRV at t+1, FIN at t+2*NIBBLES+1, back in IDLE at t+2*NIBBLES+2. Pop latency is identical.
- SP_D_nU changes only while nSK_EN=1 or at a state entry where SPC=0. SPC is never high in two consecutive cycles.
- level is $clog2(DEPTH)+1 bits wide and never wraps when the guard is enabled.
- Reset during a transfer aborts it immediately:
  - Bus is released and the SP block is reset by the same RST.
  - level returns to 0 and POP_DATA is cleared.
  - No DONE pulse.

Optional Feature:
- Macro STACK_GUARD_EN.
- Defined:
  - A push with level > DEPTH-NIBBLES, or a pop with level < NIBBLES, is rejected in IDLE.
  - Rejection: ERR=1 for one cycle, no bus or strobe activity, BUSY stays 0, state stays IDLE, level unchanged.
- Undefined:
  - No checks. ERR is tied to 0.
  - level is not implemented; the stack wraps silently modulo DEPTH.

Decomposition:
- Package stack_seq_pkg: state encoding enum (IDLE, P_DRV, P_STEP, Q_STEP, Q_READ, FIN), default NIBBLES/DEPTH constants, the bus-direction constants SP_DIR_PUSH=1 and SP_DIR_POP=0.
- No sub-module. The nibble mux and demux stay inline.
- The tristate driver on STOREBUS lives in this module, enabled in P_DRV and P_STEP only.

Test Plan:
- Push 12'hA5C from reset:
  - STOREBUS carries C, 5, A in successive P_DRV/P_STEP pairs, with SPC high on cycles 2, 4 and 6.
  - DONE at cycle 7, BUSY low at cycle 8.
- Pop after that push, with a bench SRAM model:
  - SPC high on cycles 1, 3 and 5, STOREBUS=Z throughout.
  - POP_DATA=12'hA5C on the DONE cycle.
- PUSH_REQ and POP_REQ high together in IDLE: a push sequence runs, POP_DATA is unchanged, and exactly one DONE pulse occurs.
- With STACK_GUARD_EN, after reset: POP_REQ gives ERR for one cycle with no SPC pulse and nSK_EN stuck at 1. 85 pushes are accepted (255 nibbles); the 86th gives ERR.
- RST low during P_STEP of the second nibble: all outputs return to reset values asynchronously, STOREBUS is released, and no DONE pulse occurs; a subsequent pop with the guard enabled gives ERR.
- PUSH_REQ pulsed again while BUSY: the request is ignored and there is exactly one DONE per accepted request.
